// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor (2-bit counters) with a tagged BTB and split lookup/update ports.
// Optional lookup/mispredict statistics counters are built when GSHARE_BP_STATS_EN is defined.
module gshare_branch_predictor #(
  parameter int ADDR_WIDTH      = 13,
  parameter int PRED_TABLE_SIZE = 16,
  parameter int GHR_WIDTH       = 4
) (
  input  logic                  clk,
  input  logic                  pon_rst_i,
  input  logic                  pred_req_valid,
  output logic                  pred_req_ready,
  input  logic [ADDR_WIDTH-1:0] pred_pc,
  output logic                  pred_rsp_valid,
  output logic                  pred_rsp_taken,
  output logic                  pred_rsp_hit,
  output logic [ADDR_WIDTH-1:0] pred_rsp_target,
  output logic [GHR_WIDTH-1:0]  pred_rsp_ghr,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic [GHR_WIDTH-1:0]  upd_ghr,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  input  logic                  upd_mispredict,
  output logic [15:0]           stat_lookups,
  output logic [15:0]           stat_mispredicts
);

  localparam int IDX_W = $clog2(PRED_TABLE_SIZE);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] init_idx;

  logic [1:0]            cnt_tbl [PRED_TABLE_SIZE];
  logic                  btb_vld [PRED_TABLE_SIZE];
  logic [TAG_W-1:0]      btb_tag [PRED_TABLE_SIZE];
  logic [ADDR_WIDTH-1:0] btb_tgt [PRED_TABLE_SIZE];
  logic [GHR_WIDTH-1:0]  ghr;

  function automatic logic [1:0] cnt_next(input logic [1:0] c, input logic taken);
    logic [1:0] n;
    n = c;
    if (taken && c != 2'b11) begin
      n = c + 2'b01;
    end else if (!taken && c != 2'b00) begin
      n = c - 2'b01;
    end
    return n;
  endfunction

  // Appending the new outcome below the history and dropping the top bit also covers GHR_WIDTH=1.
  function automatic logic [GHR_WIDTH-1:0] ghr_shift(input logic [GHR_WIDTH-1:0] g,
                                                     input logic t);
    logic [GHR_WIDTH:0] w;
    w = {g, t};
    return w[GHR_WIDTH-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] dir_index(input logic [IDX_W-1:0] pc_lo,
                                                 input logic [GHR_WIDTH-1:0] h);
    return pc_lo ^ IDX_W'(h);
  endfunction

  logic                  accept;
  logic                  upd_en;
  logic [IDX_W-1:0]      lk_btb_idx;
  logic [IDX_W-1:0]      lk_dir_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic                  lk_hit;
  logic                  lk_taken;
  logic [ADDR_WIDTH-1:0] lk_target;
  logic [IDX_W-1:0]      up_btb_idx;
  logic [IDX_W-1:0]      up_dir_idx;
  logic [TAG_W-1:0]      up_tag;

  // A mispredict repair owns the GHR this cycle, so lookups are held off.
  assign pred_req_ready = !pon_rst_i && (state == ST_RUN) && !(upd_valid && upd_mispredict);
  assign accept         = pred_req_valid && pred_req_ready;
  assign upd_en         = !pon_rst_i && (state == ST_RUN) && upd_valid;

  always_comb begin
    lk_btb_idx = pred_pc[IDX_W-1:0];
    lk_tag     = pred_pc[ADDR_WIDTH-1:IDX_W];
    lk_dir_idx = dir_index(pred_pc[IDX_W-1:0], ghr);
    lk_hit     = btb_vld[lk_btb_idx] && (btb_tag[lk_btb_idx] == lk_tag);
    lk_taken   = lk_hit && cnt_tbl[lk_dir_idx][1];
    lk_target  = lk_taken ? btb_tgt[lk_btb_idx] : pred_pc + ADDR_WIDTH'(1);
  end

  always_comb begin
    up_btb_idx = upd_pc[IDX_W-1:0];
    up_tag     = upd_pc[ADDR_WIDTH-1:IDX_W];
    up_dir_idx = dir_index(upd_pc[IDX_W-1:0], upd_ghr);
  end

  always_ff @(posedge clk) begin
    if (pon_rst_i) begin
      state    <= ST_INIT;
      init_idx <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          init_idx <= init_idx + IDX_W'(1);
          if (init_idx == IDX_W'(PRED_TABLE_SIZE - 1)) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Table storage; the registered response reads the old contents, giving read-before-write.
  always_ff @(posedge clk) begin
    if (!pon_rst_i && state == ST_INIT) begin
      cnt_tbl[init_idx] <= 2'b01;
      btb_vld[init_idx] <= 1'b0;
      btb_tgt[init_idx] <= '0;
    end else if (upd_en) begin
      cnt_tbl[up_dir_idx] <= cnt_next(cnt_tbl[up_dir_idx], upd_taken);
      if (upd_taken) begin
        btb_vld[up_btb_idx] <= 1'b1;
        btb_tag[up_btb_idx] <= up_tag;
        btb_tgt[up_btb_idx] <= upd_target;
      end
    end
  end

  // Lookup stage boundary: response registered one cycle after accept.
  always_ff @(posedge clk) begin
    if (pon_rst_i) begin
      pred_rsp_valid  <= 1'b0;
      pred_rsp_taken  <= 1'b0;
      pred_rsp_hit    <= 1'b0;
      pred_rsp_target <= '0;
      pred_rsp_ghr    <= '0;
      ghr             <= '0;
    end else begin
      pred_rsp_valid <= accept;
      if (accept) begin
        pred_rsp_taken  <= lk_taken;
        pred_rsp_hit    <= lk_hit;
        pred_rsp_target <= lk_target;
        pred_rsp_ghr    <= ghr;
        ghr             <= ghr_shift(ghr, lk_taken);
      end else if (upd_en && upd_mispredict) begin
        ghr <= ghr_shift(upd_ghr, upd_taken);
      end
    end
  end

`ifdef GSHARE_BP_STATS_EN
  logic [15:0] lookups_cnt;
  logic [15:0] mispred_cnt;

  always_ff @(posedge clk) begin
    if (pon_rst_i) begin
      lookups_cnt <= '0;
      mispred_cnt <= '0;
    end else begin
      if (accept && lookups_cnt != 16'hFFFF) begin
        lookups_cnt <= lookups_cnt + 16'd1;
      end
      if (upd_valid && upd_mispredict && mispred_cnt != 16'hFFFF) begin
        mispred_cnt <= mispred_cnt + 16'd1;
      end
    end
  end

  assign stat_lookups     = lookups_cnt;
  assign stat_mispredicts = mispred_cnt;
`else
  assign stat_lookups     = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for gshare_branch_predictor: per-cycle comparison against an array-based model
// plus literal expectations for the hand-worked scenarios.
module tb_gshare_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_req_valid;
  logic        pred_req_ready;
  logic [12:0] pred_pc;
  logic        pred_rsp_valid;
  logic        pred_rsp_taken;
  logic        pred_rsp_hit;
  logic [12:0] pred_rsp_target;
  logic [3:0]  pred_rsp_ghr;
  logic        upd_valid;
  logic [12:0] upd_pc;
  logic [3:0]  upd_ghr;
  logic        upd_taken;
  logic [12:0] upd_target;
  logic        upd_mispredict;
  logic [15:0] stat_lookups;
  logic [15:0] stat_mispredicts;

`ifdef GSHARE_BP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  gshare_branch_predictor dut (
    .clk              (clk),
    .pon_rst_i        (rst),
    .pred_req_valid   (pred_req_valid),
    .pred_req_ready   (pred_req_ready),
    .pred_pc          (pred_pc),
    .pred_rsp_valid   (pred_rsp_valid),
    .pred_rsp_taken   (pred_rsp_taken),
    .pred_rsp_hit     (pred_rsp_hit),
    .pred_rsp_target  (pred_rsp_target),
    .pred_rsp_ghr     (pred_rsp_ghr),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_ghr          (upd_ghr),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .stat_lookups     (stat_lookups),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integer tables updated at each rising edge.
  int m_cnt [16];
  bit m_bv  [16];
  int m_btag[16];
  int m_btgt[16];
  int m_ghr;
  int m_init_left;
  bit m_run = 1'b0;
  bit m_rst_seen = 1'b0;
  bit e_valid = 1'b0, e_taken = 1'b0, e_hit = 1'b0;
  int e_tgt = 0, e_ghr = 0;
  int m_lk = 0, m_mis = 0;

  always @(posedge clk) begin
    int bi, di, nghr;
    bit hit, tk, rdy;
    m_rst_seen = rst;
    if (rst) begin
      m_run = 1'b0; m_init_left = 16; m_ghr = 0;
      e_valid = 1'b0; e_taken = 1'b0; e_hit = 1'b0; e_tgt = 0; e_ghr = 0;
      m_lk = 0; m_mis = 0;
    end else begin
      rdy = m_run && !(upd_valid && upd_mispredict);
      nghr = m_ghr;
      e_valid = 1'b0;
      if (rdy && pred_req_valid) begin
        bi = int'(pred_pc) % 16;
        di = bi ^ m_ghr;
        hit = m_bv[bi] && (m_btag[bi] == int'(pred_pc) / 16);
        tk = hit && (m_cnt[di] >= 2);
        e_valid = 1'b1; e_hit = hit; e_taken = tk; e_ghr = m_ghr;
        e_tgt = tk ? m_btgt[bi] : (int'(pred_pc) + 1) % 8192;
        nghr = (m_ghr * 2 + int'(tk)) % 16;
        if (m_lk < 65535) m_lk++;
      end
      if (upd_valid && upd_mispredict && m_mis < 65535) m_mis++;
      if (m_run && upd_valid) begin
        di = (int'(upd_pc) % 16) ^ int'(upd_ghr);
        if (upd_taken) m_cnt[di] = (m_cnt[di] == 3) ? 3 : m_cnt[di] + 1;
        else           m_cnt[di] = (m_cnt[di] == 0) ? 0 : m_cnt[di] - 1;
        if (upd_taken) begin
          bi = int'(upd_pc) % 16;
          m_bv[bi] = 1'b1;
          m_btag[bi] = int'(upd_pc) / 16;
          m_btgt[bi] = int'(upd_target);
        end
        if (upd_mispredict) nghr = (int'(upd_ghr) * 2 + int'(upd_taken)) % 16;
      end
      if (!m_run) begin
        m_init_left--;
        if (m_init_left == 0) begin
          m_run = 1'b1;
          for (int i = 0; i < 16; i++) begin
            m_cnt[i] = 1; m_bv[i] = 1'b0; m_btgt[i] = 0; m_btag[i] = 0;
          end
        end
      end
      m_ghr = nghr;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", pred_req_ready, !rst && m_run && !(upd_valid && upd_mispredict));
      chk("rsp_valid", pred_rsp_valid, e_valid);
      if (m_rst_seen || e_valid) begin
        chk("rsp_taken", pred_rsp_taken, e_taken);
        chk("rsp_hit", pred_rsp_hit, e_hit);
        chk("rsp_target", pred_rsp_target, e_tgt);
        chk("rsp_ghr", pred_rsp_ghr, e_ghr);
      end
      chk("stat_lookups", stat_lookups, STATS ? m_lk : 0);
      chk("stat_mispredicts", stat_mispredicts, STATS ? m_mis : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [12:0] pc);
    int n = 0;
    pred_req_valid = 1'b1;
    pred_pc = pc;
    #1;
    while (!pred_req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("lookup_ready_timeout", pred_req_ready, 1'b1);
    tick();
    pred_req_valid = 1'b0;
  endtask

  task automatic upd(input logic [12:0] pc, input logic [3:0] g, input logic t,
                     input logic [12:0] tgt, input logic mis);
    upd_valid = 1'b1; upd_pc = pc; upd_ghr = g; upd_taken = t;
    upd_target = tgt; upd_mispredict = mis;
    tick();
    upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic rsp_lit(input string name, input logic tk, input logic ht,
                         input logic [12:0] tgt, input logic [3:0] g);
    chk({name, "_valid"}, pred_rsp_valid, 1'b1);
    chk({name, "_taken"}, pred_rsp_taken, tk);
    chk({name, "_hit"}, pred_rsp_hit, ht);
    chk({name, "_target"}, pred_rsp_target, tgt);
    chk({name, "_ghr"}, pred_rsp_ghr, g);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pred_req_valid = 1'b0; pred_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_taken = 1'b0;
    upd_target = '0; upd_mispredict = 1'b0;
    tick();
    chk_en = 1'b1;
    tick(); tick();

    // Reset release with a pending lookup: 16 INIT cycles, then accept.
    pred_req_valid = 1'b1; pred_pc = 13'h0040; rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1 chk("init_ready_low", pred_req_ready, 1'b0);
      tick();
    end
    #1 chk("run_ready_high", pred_req_ready, 1'b1);
    tick();
    pred_req_valid = 1'b0;
    rsp_lit("first", 1'b0, 1'b0, 13'h0041, 4'h0);

    // Train taken twice, then predict taken from the BTB.
    upd(13'h0040, 4'h0, 1'b1, 13'h1234, 1'b0);
    upd(13'h0040, 4'h0, 1'b1, 13'h1234, 1'b0);
    lookup(13'h0040);
    rsp_lit("trained", 1'b1, 1'b1, 13'h1234, 4'h0);

    // Five not-taken updates floor the counter; flush history with untrained lookups.
    for (int i = 0; i < 5; i++) upd(13'h0040, 4'h0, 1'b0, 13'h0000, 1'b0);
    lookup(13'h0005);
    rsp_lit("ghr_after_taken", 1'b0, 1'b0, 13'h0006, 4'h1);
    for (int i = 0; i < 3; i++) lookup(13'h0005);
    lookup(13'h0040);
    rsp_lit("floored", 1'b0, 1'b1, 13'h0041, 4'h0);
    upd(13'h0040, 4'h0, 1'b1, 13'h1234, 1'b0);
    lookup(13'h0040);
    rsp_lit("no_wrap", 1'b0, 1'b1, 13'h0041, 4'h0);

    // Mispredict repair blocks the same-cycle lookup and rewrites history.
    upd_valid = 1'b1; upd_mispredict = 1'b1; upd_ghr = 4'b0101; upd_taken = 1'b1;
    upd_pc = 13'h0007; upd_target = 13'h0100;
    pred_req_valid = 1'b1; pred_pc = 13'h0005;
    #1 chk("repair_blocks_ready", pred_req_ready, 1'b0);
    tick();
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    lookup(13'h0005);
    rsp_lit("repaired", 1'b0, 1'b0, 13'h0006, 4'b1011);

    // Tag mismatch on a shared index, and PC wrap on fall-through.
    upd(13'h0040, 4'h0, 1'b1, 13'h1234, 1'b0);
    lookup(13'h0050);
    rsp_lit("tag_miss", 1'b0, 1'b0, 13'h0051, 4'b0110);
    lookup(13'h1FFF);
    rsp_lit("pc_wrap", 1'b0, 1'b0, 13'h0000, 4'b1100);

    // Mid-run reset with a request pending, then statistics from a clean start.
    pred_req_valid = 1'b1; rst = 1'b1;
    tick(); tick();
    pred_req_valid = 1'b0; rst = 1'b0;
    #1 chk("reset_rsp_valid", pred_rsp_valid, 1'b0);
    chk("reset_stat_lookups", stat_lookups, 16'd0);
    lookup(13'h0010);
    lookup(13'h0020);
    lookup(13'h0030);
    upd(13'h0003, 4'h0, 1'b0, 13'h0000, 1'b1);
    upd(13'h0004, 4'h2, 1'b1, 13'h0200, 1'b1);
    #1 chk("stat_lookups_3", stat_lookups, STATS ? 16'd3 : 16'd0);
    chk("stat_mispredicts_2", stat_mispredicts, STATS ? 16'd2 : 16'd0);
    rst = 1'b1;
    tick(); tick();
    chk("stat_lookups_rst", stat_lookups, 16'd0);
    chk("stat_mispredicts_rst", stat_mispredicts, 16'd0);
    rst = 1'b0;
    tick(); tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
